// File: rtl/udatapath_microsequencer.sv
// Microprogrammed sequencer for the uDataPath register/ALU datapath: a loadable
// microprogram RAM stepped FETCH/ISSUE, with zero-flag branching and a runaway limit.
module udatapath_microsequencer #(
  parameter int DATAWIDTH_MUX_SELECTION = 6,
  parameter int DATAWIDTH_ALU_SELECTION = 4,
  parameter int UPC_WIDTH               = 5,
  parameter int MAX_STEPS               = 255,
  parameter int UWORD_WIDTH             = 3*DATAWIDTH_MUX_SELECTION+DATAWIDTH_ALU_SELECTION+3+UPC_WIDTH
) (
  input  logic                               UDATAPATH_MICROSEQUENCER_CLOCK_50,
  input  logic                               UDATAPATH_MICROSEQUENCER_Reset_InHigh,
  input  logic                               UDATAPATH_MICROSEQUENCER_Load_In,
  input  logic [UPC_WIDTH-1:0]               UDATAPATH_MICROSEQUENCER_LoadAddr_In,
  input  logic [UWORD_WIDTH-1:0]             UDATAPATH_MICROSEQUENCER_LoadData_In,
  input  logic                               UDATAPATH_MICROSEQUENCER_Start_In,
  input  logic [UPC_WIDTH-1:0]               UDATAPATH_MICROSEQUENCER_StartAddr_In,
  input  logic                               UDATAPATH_MICROSEQUENCER_AluZero_In,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] UDATAPATH_MICROSEQUENCER_SelA_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] UDATAPATH_MICROSEQUENCER_SelB_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0] UDATAPATH_MICROSEQUENCER_SelC_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] UDATAPATH_MICROSEQUENCER_AluOp_Out,
  output logic                               UDATAPATH_MICROSEQUENCER_Write_Out,
  output logic                               UDATAPATH_MICROSEQUENCER_Busy_Out,
  output logic                               UDATAPATH_MICROSEQUENCER_Done_Out,
  output logic                               UDATAPATH_MICROSEQUENCER_Abort_Out,
  output logic [UPC_WIDTH-1:0]               UDATAPATH_MICROSEQUENCER_UPC_Out
);

  localparam int MW       = DATAWIDTH_MUX_SELECTION;
  localparam int AW       = DATAWIDTH_ALU_SELECTION;
  localparam int COND_LSB = UPC_WIDTH;
  localparam int WR_BIT   = UPC_WIDTH + 2;
  localparam int ALU_LSB  = UPC_WIDTH + 3;
  localparam int SELC_LSB = ALU_LSB + AW;
  localparam int SELB_LSB = SELC_LSB + MW;
  localparam int SELA_LSB = SELB_LSB + MW;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ISSUE = 2'd2, DONE = 2'd3} state_t;

  logic [UWORD_WIDTH-1:0] uRam [0:(2**UPC_WIDTH)-1];

  state_t                 state_r, nextState_s;
  logic [UPC_WIDTH-1:0]   upc_r, nextUpc_s, upcInc_s, target_s;
  logic [UWORD_WIDTH-1:0] ir_r, nextIr_s, issueWord_s;
  logic [7:0]             stepCnt_r, nextCnt_s, cntInc_s;
  logic                   abort_r, nextAbort_s;
  logic [1:0]             cond_s;
  logic                   ramWrite_s;

  logic [MW-1:0]          selA_r, selB_r, selC_r;
  logic [AW-1:0]          aluOp_r;
  logic                   write_r, busy_r, done_r;

  assign ramWrite_s = UDATAPATH_MICROSEQUENCER_Load_In && (state_r == IDLE);
  assign upcInc_s   = upc_r + UPC_WIDTH'(1);
  assign cntInc_s   = stepCnt_r + 8'd1;
  assign cond_s     = ir_r[COND_LSB +: 2];
  assign target_s   = ir_r[UPC_WIDTH-1:0];

  // Microprogram storage; deliberately not reset so a loaded program survives reset.
  always_ff @(posedge UDATAPATH_MICROSEQUENCER_CLOCK_50) begin
    if (ramWrite_s) begin
      uRam[UDATAPATH_MICROSEQUENCER_LoadAddr_In] <= UDATAPATH_MICROSEQUENCER_LoadData_In;
    end
  end

  // Next-state, microprogram counter, step count and abort computation.
  always_comb begin
    nextState_s = state_r;
    nextUpc_s   = upc_r;
    nextIr_s    = ir_r;
    nextCnt_s   = stepCnt_r;
    nextAbort_s = abort_r;
    case (state_r)
      IDLE: begin
        if (UDATAPATH_MICROSEQUENCER_Start_In) begin
          nextUpc_s   = UDATAPATH_MICROSEQUENCER_StartAddr_In;
          nextCnt_s   = 8'd0;
          nextAbort_s = 1'b0;
          nextState_s = FETCH;
        end else begin
          nextState_s = IDLE;
        end
      end
      FETCH: begin
        nextIr_s    = uRam[upc_r];
        nextState_s = ISSUE;
      end
      ISSUE: begin
        nextCnt_s = cntInc_s;
        case (cond_s)
          2'b00:   nextUpc_s = upcInc_s;
          2'b01:   nextUpc_s = target_s;
          2'b10:   nextUpc_s = UDATAPATH_MICROSEQUENCER_AluZero_In ? target_s : upcInc_s;
          default: nextUpc_s = upc_r;
        endcase
        if (cond_s == 2'b11) begin
          nextState_s = DONE;
        end else if (cntInc_s == 8'(MAX_STEPS)) begin
          nextAbort_s = 1'b1;
          nextState_s = DONE;
        end else begin
          nextState_s = FETCH;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
    // Outputs are registered from the word that will be live in the upcoming ISSUE cycle.
    issueWord_s = (nextState_s == ISSUE) ? nextIr_s : {UWORD_WIDTH{1'b0}};
  end

  // State, datapath control registers and registered outputs.
  always_ff @(posedge UDATAPATH_MICROSEQUENCER_CLOCK_50 or posedge UDATAPATH_MICROSEQUENCER_Reset_InHigh) begin
    if (UDATAPATH_MICROSEQUENCER_Reset_InHigh) begin
      state_r   <= IDLE;
      upc_r     <= {UPC_WIDTH{1'b0}};
      ir_r      <= {UWORD_WIDTH{1'b0}};
      stepCnt_r <= 8'd0;
      abort_r   <= 1'b0;
      selA_r    <= {MW{1'b0}};
      selB_r    <= {MW{1'b0}};
      selC_r    <= {MW{1'b0}};
      aluOp_r   <= {AW{1'b0}};
      write_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= nextState_s;
      upc_r     <= nextUpc_s;
      ir_r      <= nextIr_s;
      stepCnt_r <= nextCnt_s;
      abort_r   <= nextAbort_s;
      selA_r    <= issueWord_s[SELA_LSB +: MW];
      selB_r    <= issueWord_s[SELB_LSB +: MW];
      selC_r    <= issueWord_s[SELC_LSB +: MW];
      aluOp_r   <= issueWord_s[ALU_LSB +: AW];
      write_r   <= issueWord_s[WR_BIT];
      busy_r    <= (nextState_s != IDLE);
      done_r    <= (nextState_s == DONE);
    end
  end

  assign UDATAPATH_MICROSEQUENCER_SelA_Out  = selA_r;
  assign UDATAPATH_MICROSEQUENCER_SelB_Out  = selB_r;
  assign UDATAPATH_MICROSEQUENCER_SelC_Out  = selC_r;
  assign UDATAPATH_MICROSEQUENCER_AluOp_Out = aluOp_r;
  assign UDATAPATH_MICROSEQUENCER_Write_Out = write_r;
  assign UDATAPATH_MICROSEQUENCER_Busy_Out  = busy_r;
  assign UDATAPATH_MICROSEQUENCER_Done_Out  = done_r;
  assign UDATAPATH_MICROSEQUENCER_Abort_Out = abort_r;
  assign UDATAPATH_MICROSEQUENCER_UPC_Out   = upc_r;

endmodule

// File: doc/udatapath_microsequencer.md
Name: udatapath_microsequencer

Overview:
- Microprogrammed controller that sequences the uDataPath general-register/ALU datapath.
- Holds a loadable microprogram and steps through it after a start pulse, emitting bus-A/bus-B mux selects, a bus-C write-destination select with write strobe, and an ALU operation code per microinstruction.
- Branches on the datapath ALU zero flag.
- Sits between the top-level system wrapper and the datapath, replacing hard-wired selection constants.

Parameters:
- DATAWIDTH_MUX_SELECTION, 6, width of the bus-A, bus-B and bus-C register select fields.
- DATAWIDTH_ALU_SELECTION, 4, width of the ALU op field.
- UPC_WIDTH, 5, microprogram address width; depth is 2^UPC_WIDTH words.
- MAX_STEPS, 255, issued-microinstruction limit per run before a forced abort; 8-bit counter.
- UWORD_WIDTH, 3*DATAWIDTH_MUX_SELECTION+DATAWIDTH_ALU_SELECTION+3+UPC_WIDTH (30), microword width.

Ports:
- UDATAPATH_MICROSEQUENCER_CLOCK_50  in  1  system clock, all logic on rising edge.
- UDATAPATH_MICROSEQUENCER_Reset_InHigh  in  1  asynchronous active-high reset.
- UDATAPATH_MICROSEQUENCER_Load_In  in  1  microprogram write strobe, honoured only in IDLE.
- UDATAPATH_MICROSEQUENCER_LoadAddr_In  in  UPC_WIDTH  microprogram write address.
- UDATAPATH_MICROSEQUENCER_LoadData_In  in  UWORD_WIDTH  microword. Fields MSB to LSB: selA, selB, selC, alu, wr(1), cond(2), target(UPC_WIDTH).
- UDATAPATH_MICROSEQUENCER_Start_In  in  1  start pulse, honoured only in IDLE.
- UDATAPATH_MICROSEQUENCER_StartAddr_In  in  UPC_WIDTH  first microinstruction address.
- UDATAPATH_MICROSEQUENCER_AluZero_In  in  1  datapath ALU result==0 flag, combinational from current selections.
- UDATAPATH_MICROSEQUENCER_SelA_Out  out  DATAWIDTH_MUX_SELECTION  bus-A register select.
- UDATAPATH_MICROSEQUENCER_SelB_Out  out  DATAWIDTH_MUX_SELECTION  bus-B register select.
- UDATAPATH_MICROSEQUENCER_SelC_Out  out  DATAWIDTH_MUX_SELECTION  bus-C destination code to the write decoder.
- UDATAPATH_MICROSEQUENCER_AluOp_Out  out  DATAWIDTH_ALU_SELECTION  ALU operation.
- UDATAPATH_MICROSEQUENCER_Write_Out  out  1  destination write enable.
- UDATAPATH_MICROSEQUENCER_Busy_Out  out  1  high outside IDLE.
- UDATAPATH_MICROSEQUENCER_Done_Out  out  1  one-cycle completion pulse.
- UDATAPATH_MICROSEQUENCER_Abort_Out  out  1  sticky: last run hit MAX_STEPS; cleared on next accepted start.
- UDATAPATH_MICROSEQUENCER_UPC_Out  out  UPC_WIDTH  current microprogram counter.

Behaviour:
- Reset (async, any state): state=IDLE, uPC=0, IR=0, step count=0, all outputs 0. Microprogram RAM is not reset.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - Load=1 writes RAM[LoadAddr] at the clock edge.
  - Start=1 sets uPC=StartAddr, clears step count and Abort, and goes to FETCH.
  - Load and Start in the same cycle: both take effect; FETCH sees the new word, including when LoadAddr==StartAddr.
- FETCH: IR<=RAM[uPC]; go to ISSUE. Selection outputs and Write stay 0.
- ISSUE:
  - SelA/SelB/SelC/AluOp are driven from IR; Write=IR.wr. This is the only cycle Write can be 1.
  - AluZero is sampled in the same cycle.
  - Step count increments.
  - Next uPC by cond: 00 uPC+1; 01 target; 10 target if AluZero else uPC+1; 11 end, go to DONE.
  - uPC+1 wraps modulo 2^UPC_WIDTH (max address goes to 0).
  - If cond!=11 and the incremented count equals MAX_STEPS: set Abort and go to DONE. The current instruction's write still occurs.
  - Otherwise go to FETCH.
- Throughput: 2 cycles per microinstruction. Start-accept to first ISSUE is 2 cycles.
- DONE: Done=1 for exactly one cycle, Busy=1, selections 0; next state is IDLE.
- Busy=1 in FETCH, ISSUE and DONE. Start and Load are ignored while Busy.
- Outside ISSUE, SelA/SelB/SelC/AluOp/Write are all 0.
- UPC_Out shows uPC in every state.

Test Plan:
- Reset mid-run: assert reset during ISSUE with Write=1 -> same cycle Write=0, Busy=0, UPC=0; after release, an IDLE start runs normally and RAM contents are retained.
- Straight-line run: load addr0 {selA=1,selB=2,selC=3,alu=4'h1,wr=1,cond=00} and addr1 {cond=11,wr=0}; pulse Start with addr 0 -> Write=1 with SelC=3 exactly once, 2 cycles after start; Done pulses 5 cycles after start; Abort=0.
- Conditional branch: addr0 {cond=10,target=5}, addr5 {cond=11}; AluZero=1 -> UPC goes 0 to 5. Repeat with AluZero=0 -> UPC goes 0 to 1.
- Wrap and runaway: start at 31 with word31 {cond=00}; all other words {cond=01,target=0} -> UPC goes 31 to 0; with MAX_STEPS=255, Abort=1 and Done pulses after 255 ISSUE cycles.
- Protection: pulse Load and Start during Busy -> RAM unchanged, run unaffected. Load addr 2 and Start at 2 in the same IDLE cycle -> the new word is issued.
